mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have no parameters; data and address widths are fixed at 32 bits and memory is byte-addressed, little-endian.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset, with these ports:
  clk  in  1  clock, rising edge
  rst  in  1  synchronous active-high reset
  if_req  in  1  instruction fetch request, held until if_ready
  if_addr  in  32  fetch byte address
  if_ready  out  1  one-cycle fetch completion pulse
  if_rdata  out  32  fetched instruction, valid with if_ready
  if_misalign  out  1  fetch fault, valid with if_ready
  d_req  in  1  data request, held until d_ready
  d_we  in  1  1 = store, 0 = load
  d_size  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as word
  d_unsigned  in  1  load zero-extends when 1, sign-extends when 0
  d_addr  in  32  data byte address
  d_wdata  in  32  store data, right-aligned
  d_ready  out  1  one-cycle data completion pulse
  d_rdata  out  32  extended load result, valid with d_ready
  d_misalign  out  1  data fault, valid with d_ready
  mem_en  out  1  memory access strobe
  mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
  mem_we  out  4  byte-lane write enables
  mem_wdata  out  32  lane-positioned write data
  mem_rdata  in  32  read word, valid the cycle after mem_en

Function
REQ-003 The module SHALL implement the FSM states IDLE, BUSY_I and BUSY_D.
REQ-004 In IDLE, with exactly one request asserted, the module SHALL grant that request: assert mem_en and drive mem_addr, mem_we and mem_wdata combinationally from that requester in the same cycle, then go to BUSY_I or BUSY_D.
REQ-005 When both requests are asserted in IDLE, the module SHALL grant the requester not granted last (round-robin) and update last_grant on every grant.
REQ-006 In BUSY_x, the module SHALL pulse x_ready for exactly one cycle, drive x_rdata from mem_rdata, keep mem_en=0, and return to IDLE.
REQ-007 A request still asserted in the IDLE cycle after ready SHALL be treated as a new request; peak throughput is one access per 2 cycles.
REQ-008 Every output of a requester not in its ready cycle SHALL be 0.
REQ-009 Store lanes SHALL be: byte mem_we=4'b0001<<addr[1:0] with mem_wdata holding d_wdata[7:0] replicated in all lanes; half mem_we=4'b0011<<(2*addr[1]) with d_wdata[15:0] replicated; word mem_we=4'b1111 with mem_wdata=d_wdata.
REQ-010 A load SHALL extract the byte at lane addr[1:0], or the half at lane addr[1], and zero- or sign-extend it to 32 bits per d_unsigned.
REQ-011 mem_we SHALL be 0 for loads and fetches; the granted address, size and unsigned flag SHALL be registered at grant for the REQ-010 extraction.
REQ-012 A misaligned access SHALL perform no memory access: half at an odd address, word with addr[1:0]!=0, or fetch with if_addr[1:0]!=0.
REQ-013 For a misaligned access, the module SHALL keep mem_en=0 and mem_we=0, still use BUSY_x, and pulse x_ready with x_misalign=1 and x_rdata=0.
REQ-014 A misaligned grant SHALL still update last_grant.

Reset
REQ-015 While rst=1 at a clock edge, the module SHALL set state to IDLE, last_grant to D, and all outputs to 0.
REQ-016 Reset during BUSY_x SHALL abandon the access, so no ready pulse is produced for it.

Verification
REQ-017 Fetch if_addr=0x10 with mem_rdata=0x00940093 -> mem_en=1 and mem_addr=0x10 in cycle 0; if_ready=1 and if_rdata=0x00940093 in cycle 1.
REQ-018 Simultaneous if_req and d_req after reset -> fetch granted first, then data 2 cycles later; a repeated conflict alternates grants.
REQ-019 Store byte 0xAB at d_addr=0x23 -> mem_addr=0x20, mem_we=4'b1000, mem_wdata=0xABABABAB.
REQ-020 Load half at 0x22 with mem_rdata=0x8001_0000: d_unsigned=0 gives d_rdata=0xFFFF8001; d_unsigned=1 gives d_rdata=0x00008001.
REQ-021 Word load at 0x06 -> mem_en stays 0; d_ready=1, d_misalign=1, d_rdata=0 one cycle later.
REQ-022 rst asserted in the BUSY_D cycle -> no d_ready, and all outputs are 0 the following cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Fetch/data requester ports plus the single-ported memory bus of the arbiter.
// Requests are level-held until the matching one-cycle ready pulse.
// slave = arbiter view, master = requester/memory view.
interface mem_arbiter_if;
  // instruction fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_misalign;
  // data port
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_misalign;
  // memory side
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_ready, if_rdata, if_misalign,
    input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    output d_ready, d_rdata, d_misalign,
    output mem_en, mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_ready, if_rdata, if_misalign,
    output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    input  d_ready, d_rdata, d_misalign,
    input  mem_en, mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between fetch and data requesters.
// Latency: grant drives the memory bus in the request cycle, ready pulses one cycle later.
// Backpressure: requests are held until ready; at most one access per two cycles.
module mem_arbiter (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_d;     // 1 = data port was granted most recently
  logic [1:0]  r_lo;         // byte offset of the granted data access
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_mis;        // granted access was misaligned, no memory cycle made

  logic        w_grant_i;
  logic        w_grant_d;
  logic        w_if_mis;
  logic        w_d_mis;
  logic [3:0]  w_st_we;
  logic [31:0] w_st_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_ext;

  // Alignment faults for both requesters; size 11 behaves as a word.
  always_comb begin
    w_if_mis = |bus.if_addr[1:0];
    case (bus.d_size)
      2'b00:   w_d_mis = 1'b0;
      2'b01:   w_d_mis = bus.d_addr[0];
      default: w_d_mis = |bus.d_addr[1:0];
    endcase
  end

  // Store lane enables and lane-replicated write data.
  always_comb begin
    case (bus.d_size)
      2'b00: begin
        w_st_we    = 4'b0001 << bus.d_addr[1:0];
        w_st_wdata = {4{bus.d_wdata[7:0]}};
      end
      2'b01: begin
        w_st_we    = 4'b0011 << {bus.d_addr[1], 1'b0};
        w_st_wdata = {2{bus.d_wdata[15:0]}};
      end
      default: begin
        w_st_we    = 4'b1111;
        w_st_wdata = bus.d_wdata;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension from the registered access info.
  always_comb begin
    w_ld_byte = bus.mem_rdata[{r_lo, 3'b000} +: 8];
    w_ld_half = r_lo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_size)
      2'b00:   w_ld_ext = r_unsigned ? {24'd0, w_ld_byte}
                                     : {{24{w_ld_byte[7]}}, w_ld_byte};
      2'b01:   w_ld_ext = r_unsigned ? {16'd0, w_ld_half}
                                     : {{16{w_ld_half[15]}}, w_ld_half};
      default: w_ld_ext = bus.mem_rdata;
    endcase
  end

  // Grant selection: only in IDLE, conflicts go to the port not granted last.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (!rst && r_state == IDLE) begin
      if (bus.if_req && bus.d_req) begin
        w_grant_i = r_last_d;
        w_grant_d = !r_last_d;
      end else begin
        w_grant_i = bus.if_req;
        w_grant_d = bus.d_req;
      end
    end
  end

  // Next state plus all bus outputs; everything is forced to zero while in reset.
  always_comb begin
    w_state_nxt     = r_state;
    bus.mem_en      = 1'b0;
    bus.mem_addr    = 32'd0;
    bus.mem_we      = 4'd0;
    bus.mem_wdata   = 32'd0;
    bus.if_ready    = 1'b0;
    bus.if_rdata    = 32'd0;
    bus.if_misalign = 1'b0;
    bus.d_ready     = 1'b0;
    bus.d_rdata     = 32'd0;
    bus.d_misalign  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_i) begin
          w_state_nxt = BUSY_I;
          if (!w_if_mis) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = {bus.if_addr[31:2], 2'b00};
          end
        end else if (w_grant_d) begin
          w_state_nxt = BUSY_D;
          if (!w_d_mis) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = {bus.d_addr[31:2], 2'b00};
            if (bus.d_we) begin
              bus.mem_we    = w_st_we;
              bus.mem_wdata = w_st_wdata;
            end
          end
        end
      end
      BUSY_I: begin
        w_state_nxt = IDLE;
        if (!rst) begin
          bus.if_ready    = 1'b1;
          bus.if_misalign = r_mis;
          bus.if_rdata    = r_mis ? 32'd0 : bus.mem_rdata;
        end
      end
      BUSY_D: begin
        w_state_nxt = IDLE;
        if (!rst) begin
          bus.d_ready    = 1'b1;
          bus.d_misalign = r_mis;
          bus.d_rdata    = r_mis ? 32'd0 : w_ld_ext;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, round-robin history and the access info captured at grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_d   <= 1'b1;
      r_lo       <= 2'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_mis      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_i) begin
        r_last_d <= 1'b0;
        r_mis    <= w_if_mis;
      end else if (w_grant_d) begin
        r_last_d   <= 1'b1;
        r_mis      <= w_d_mis;
        r_lo       <= bus.d_addr[1:0];
        r_size     <= bus.d_size;
        r_unsigned <= bus.d_unsigned;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory responder, reference memory and an in-order response scoreboard.
// Checks grant-cycle bus values, ready latency, load extension, faults and reset abandonment.
// Requesters hold their request until the matching ready is seen.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  mem_arbiter_if bus ();

  mem_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic        mis;
    logic        chk_rd;
    logic [31:0] rdata;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] mem     [0:63];   // written by the DUT's memory bus
  logic [31:0] ref_mem [0:63];   // written by the bench from request semantics
  int          n_chk;
  int          n_bad;
  logic        last_d;

  // staged request fields
  logic [31:0] s_iaddr;
  logic        s_dwe;
  logic [1:0]  s_dsz;
  logic        s_duns;
  logic [31:0] s_daddr;
  logic [31:0] s_dwdata;
  int          s_mchk;           // 0 none, 1 en/we only, 2 full bus
  logic        s_men;
  logic [31:0] s_maddr;
  logic [3:0]  s_mwe;
  logic [31:0] s_mwdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic d_mis(input logic [1:0] sz, input logic [1:0] lo);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return lo[0];
    return lo != 2'b00;
  endfunction

  function automatic logic [31:0] ld_exp(input logic [31:0] w, input logic [1:0] sz,
                                         input logic uns, input logic [1:0] lo);
    logic [31:0] sh;
    if (sz == 2'b00) begin
      sh = w >> (8 * lo);
      return uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    end
    if (sz == 2'b01) begin
      sh = w >> (16 * lo[1]);
      return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    end
    return w;
  endfunction

  // Build the expected response for one requester from the staged fields.
  task automatic push(input logic is_d);
    sb_t e;
    int  nb;
    e.is_d = is_d; e.chk_rd = 1'b1; e.rdata = 32'd0;
    if (!is_d) begin
      e.mis = s_iaddr[1:0] != 2'b00;
      if (!e.mis) e.rdata = ref_mem[s_iaddr[7:2]];
    end else begin
      e.mis = d_mis(s_dsz, s_daddr[1:0]);
      if (!e.mis) begin
        if (s_dwe) begin
          e.chk_rd = 1'b0;
          nb = (s_dsz == 2'b00) ? 1 : (s_dsz == 2'b01) ? 2 : 4;
          for (int k = 0; k < nb; k++)
            ref_mem[s_daddr[7:2]][8*(int'(s_daddr[1:0])+k) +: 8] = s_dwdata[8*k +: 8];
        end else begin
          e.rdata = ld_exp(ref_mem[s_daddr[7:2]], s_dsz, s_duns, s_daddr[1:0]);
        end
      end
    end
    sb.push_back(e);
  endtask

  // Issue a fetch, a data access, or both at once, and wait for their ready pulses.
  task automatic run(input logic ui, input logic ud);
    logic first_d, pi, pd;
    int   lat_i, lat_d;
    first_d = (ui && ud) ? !last_d : ud;
    push(first_d);
    if (ui && ud) push(!first_d);
    last_d = (ui && ud) ? !first_d : first_d;
    @(negedge clk);
    bus.if_req = ui;       bus.if_addr = s_iaddr;
    bus.d_req = ud;        bus.d_we = s_dwe;      bus.d_size = s_dsz;
    bus.d_unsigned = s_duns; bus.d_addr = s_daddr; bus.d_wdata = s_dwdata;
    #1;
    if (s_mchk > 0) begin
      chk("grant_mem_en", {31'd0, bus.mem_en}, {31'd0, s_men});
      chk("grant_mem_we", {28'd0, bus.mem_we}, {28'd0, s_mwe});
    end
    if (s_mchk > 1) begin
      chk("grant_mem_addr", bus.mem_addr, s_maddr);
      chk("grant_mem_wdata", bus.mem_wdata, s_mwdata);
    end
    s_mchk = 0;
    pi = ui; pd = ud; lat_i = 0; lat_d = 0;
    for (int c = 1; c <= 12 && (pi || pd); c++) begin
      @(negedge clk);
      if (pi && bus.if_ready) begin pi = 1'b0; lat_i = c; bus.if_req = 1'b0; end
      if (pd && bus.d_ready)  begin pd = 1'b0; lat_d = c; bus.d_req = 1'b0; end
    end
    chk("ready_timeout", {30'd0, pi, pd}, 32'd0);
    if (ui && ud) begin
      chk("lat_first",  first_d ? lat_d : lat_i, 32'd1);
      chk("lat_second", first_d ? lat_i : lat_d, 32'd3);
    end else begin
      chk("lat_single", ud ? lat_d : lat_i, 32'd1);
    end
  endtask

  task automatic stage_d(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    s_dwe = we; s_dsz = sz; s_duns = uns; s_daddr = a; s_dwdata = wd;
  endtask

  task automatic stage_m(input int mode, input logic en, input logic [31:0] a,
                         input logic [3:0] we, input logic [31:0] wd);
    s_mchk = mode; s_men = en; s_maddr = a; s_mwe = we; s_mwdata = wd;
  endtask

  // Memory model: sample the bus mid-cycle, answer with the read word after the edge.
  initial begin
    logic        en;
    logic [31:0] a, wd;
    logic [3:0]  we;
    bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk); #2;
      en = bus.mem_en; a = bus.mem_addr; we = bus.mem_we; wd = bus.mem_wdata;
      @(posedge clk); #1;
      if (en && !rst) begin
        bus.mem_rdata = mem[a[7:2]];
        for (int j = 0; j < 4; j++)
          if (we[j]) mem[a[7:2]][8*j +: 8] = wd[8*j +: 8];
      end else begin
        bus.mem_rdata = $urandom;
      end
    end
  end

  // Response monitor: pops the scoreboard on every ready pulse, idle outputs must be zero.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (bus.if_ready || bus.d_ready) begin
        chk("busy_mem_en", {31'd0, bus.mem_en}, 32'd0);
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("resp_src", {30'd0, bus.d_ready, bus.if_ready}, e.is_d ? 32'd2 : 32'd1);
          chk("resp_mis", {31'd0, e.is_d ? bus.d_misalign : bus.if_misalign}, {31'd0, e.mis});
          if (e.chk_rd) chk("resp_rdata", e.is_d ? bus.d_rdata : bus.if_rdata, e.rdata);
        end
      end
      if (!bus.if_ready) chk("if_quiet", bus.if_rdata | {31'd0, bus.if_misalign}, 32'd0);
      if (!bus.d_ready)  chk("d_quiet",  bus.d_rdata  | {31'd0, bus.d_misalign},  32'd0);
    end
  end

  function automatic logic [31:0] all_outs();
    return bus.if_rdata | bus.d_rdata | bus.mem_addr | bus.mem_wdata |
           {24'd0, bus.mem_we, bus.mem_en, bus.if_ready, bus.if_misalign,
            bus.d_ready, bus.d_misalign};
  endfunction

  initial begin
    logic ui, ud;
    n_chk = 0; n_bad = 0; last_d = 1'b1; s_mchk = 0;
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    mem[4] = 32'h0094_0093; ref_mem[4] = mem[4];
    mem[8] = 32'h8001_0000; ref_mem[8] = mem[8];
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_unsigned = 1'b0;
    bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
    s_iaddr = 32'd0; stage_d(1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    bus.if_req = 1'b1; bus.d_req = 1'b1;   // requests during reset must be ignored
    #1 chk("reset_outs", all_outs(), 32'd0);
    @(negedge clk);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // conflict right after reset: fetch first, data two cycles later
    s_iaddr = 32'h10; stage_d(1'b0, 2'b10, 1'b0, 32'h04, 32'd0);
    stage_m(2, 1'b1, 32'h10, 4'b0000, 32'd0);
    run(1'b1, 1'b1);
    // lone fetch
    s_iaddr = 32'h10; stage_m(2, 1'b1, 32'h10, 4'b0000, 32'd0);
    run(1'b1, 1'b0);
    // conflict after a fetch grant: data wins this time
    s_iaddr = 32'h14; stage_d(1'b0, 2'b00, 1'b0, 32'h05, 32'd0);
    stage_m(2, 1'b1, 32'h04, 4'b0000, 32'd0);
    run(1'b1, 1'b1);
    // half loads from the upper lane, signed and unsigned
    stage_d(1'b0, 2'b01, 1'b0, 32'h22, 32'd0); run(1'b0, 1'b1);
    stage_d(1'b0, 2'b01, 1'b1, 32'h22, 32'd0); run(1'b0, 1'b1);
    // byte store into the top lane, read back
    stage_d(1'b1, 2'b00, 1'b0, 32'h23, 32'h0000_00AB);
    stage_m(2, 1'b1, 32'h20, 4'b1000, 32'hABAB_ABAB);
    run(1'b0, 1'b1);
    stage_d(1'b0, 2'b00, 1'b1, 32'h23, 32'd0); run(1'b0, 1'b1);
    stage_d(1'b0, 2'b00, 1'b0, 32'h23, 32'd0); run(1'b0, 1'b1);
    // half store into the upper lane
    stage_d(1'b1, 2'b01, 1'b0, 32'h2A, 32'h1236_5678);
    stage_m(2, 1'b1, 32'h28, 4'b1100, 32'h5678_5678);
    run(1'b0, 1'b1);
    stage_d(1'b0, 2'b10, 1'b0, 32'h28, 32'd0); run(1'b0, 1'b1);
    // misaligned word load, half store and fetch: no memory cycle
    stage_d(1'b0, 2'b10, 1'b0, 32'h06, 32'd0); stage_m(1, 1'b0, 32'd0, 4'b0000, 32'd0);
    run(1'b0, 1'b1);
    stage_d(1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFF_FFFF); stage_m(1, 1'b0, 32'd0, 4'b0000, 32'd0);
    run(1'b0, 1'b1);
    s_iaddr = 32'h12; stage_m(1, 1'b0, 32'd0, 4'b0000, 32'd0);
    run(1'b1, 1'b0);

    // reset in the busy cycle abandons the access
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_addr = 32'h08;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy_dready", {31'd0, bus.d_ready}, 32'd0);
    chk("rst_busy_outs", all_outs(), 32'd0);
    bus.d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_outs", all_outs(), 32'd0);
    last_d = 1'b1;

    // random mix of single and conflicting requests
    for (int n = 0; n < 60; n++) begin
      ui = $urandom_range(0, 1);
      ud = ui ? 1'($urandom_range(0, 1)) : 1'b1;
      s_iaddr = {24'd0, 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 3) != 0) s_iaddr[1:0] = 2'b00;
      stage_d(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              {24'd0, 8'($urandom_range(0, 255))}, $urandom);
      if ($urandom_range(0, 3) != 0) s_daddr[1:0] = (s_dsz == 2'b00) ? s_daddr[1:0] :
                                                    (s_dsz == 2'b01) ? {s_daddr[1], 1'b0} : 2'b00;
      run(ui, ud);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
